// File: rtl/drm_ctrl_axis_pkg.sv
// rtl/drm_ctrl_axis_pkg.sv - shared constants, bit layout and types for the DRM controller AXIS bridge
package drm_ctrl_axis_pkg;

  localparam int          AXIS_W        = 32;
  localparam int          BUS_W         = 6;
  localparam logic [31:0] DRM_SYNC_WORD = 32'hFFFF_FFFF;

  // TX bus word layout: {26'b0, cs, cyc, adr[1:0], we, dat}
  localparam int BIT_CS     = 5;
  localparam int BIT_CYC    = 4;
  localparam int BIT_ADR_HI = 3;
  localparam int BIT_ADR_LO = 2;
  localparam int BIT_WE     = 1;
  localparam int BIT_DAT    = 0;

  // RX response layout in the low nibble of the return beat
  localparam int BIT_ACK  = 3;
  localparam int BIT_INTR = 2;
  localparam int BIT_STA  = 1;
  localparam int BIT_RDAT = 0;

  typedef enum logic {SYNC, RUN} tx_state_e;

  function automatic logic [BUS_W-1:0] pack_bus(input logic cs, input logic cyc,
                                                input logic [1:0] adr, input logic we,
                                                input logic dat);
    logic [BUS_W-1:0] w;
    w                         = '0;
    w[BIT_CS]                 = cs;
    w[BIT_CYC]                = cyc;
    w[BIT_ADR_HI:BIT_ADR_LO]  = adr;
    w[BIT_WE]                 = we;
    w[BIT_DAT]                = dat;
    return w;
  endfunction

endpackage

// File: rtl/drm_ctrl_axis_bridge_if.sv
// rtl/drm_ctrl_axis_bridge_if.sv - 32-bit AXI4-Stream link between the bridge and the activator
interface drm_ctrl_axis_bridge_if;
  import drm_ctrl_axis_pkg::*;

  logic              tvalid;
  logic              tready;
  logic [AXIS_W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/drm_ctrl_axis_fifo.sv
// rtl/drm_ctrl_axis_fifo.sv - first-word-fall-through synchronous FIFO for TX bus words
module drm_ctrl_axis_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Storage write; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  // Pointer update; push while full is only legal with a simultaneous pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/drm_ctrl_axis_bridge.sv
// rtl/drm_ctrl_axis_bridge.sv - controller-side DRM bus tunnel over AXI4-Stream
module drm_ctrl_axis_bridge
  import drm_ctrl_axis_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SYNC_BEATS = 16
) (
  input  logic                          drm_aclk,
  input  logic                          drm_arst,
  input  logic                          drm_bus_master_o_cs,
  input  logic                          drm_bus_master_o_cyc,
  input  logic                          drm_bus_master_o_we,
  input  logic                          drm_bus_master_o_dat,
  input  logic [1:0]                    drm_bus_master_o_adr,
  output logic                          drm_bus_master_i_ack,
  output logic                          drm_bus_master_i_intr,
  output logic                          drm_bus_master_i_sta,
  output logic                          drm_bus_master_i_dat,
  drm_ctrl_axis_bridge_if.master        drm_to_uip,
  drm_ctrl_axis_bridge_if.slave         uip_to_drm,
  output logic                          link_up,
  output logic                          tx_overflow
);

  localparam int CNT_W = $clog2(SYNC_BEATS + 1);

  tx_state_e        state_q, state_d;
  logic             active_q;
  logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [BUS_W-1:0] last_word_q, last_word_d;
  logic             overflow_q, overflow_d;
  logic [3:0]       resp_q;
  logic             link_up_q;

  logic             tx_tvalid;
  logic [31:0]      tx_tdata;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [BUS_W-1:0] fifo_head, bus_word;

  assign bus_word = pack_bus(drm_bus_master_o_cs, drm_bus_master_o_cyc, drm_bus_master_o_adr,
                             drm_bus_master_o_we, drm_bus_master_o_dat);

  drm_ctrl_axis_fifo #(.WIDTH(BUS_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (drm_aclk),
    .rst_i   (drm_arst),
    .push_i  (fifo_push),
    .din_i   (bus_word),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // TX state, sync counter, change tracker, overflow flag; active_q keeps outputs low for the cycle after reset.
  always_ff @(posedge drm_aclk) begin
    if (drm_arst) begin
      state_q     <= SYNC;
      active_q    <= 1'b0;
      sync_cnt_q  <= '0;
      last_word_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= 1'b1;
      sync_cnt_q  <= sync_cnt_d;
      last_word_q <= last_word_d;
      overflow_q  <= overflow_d;
    end
  end

  // TX next state: sync preamble, then change-detected bus words through the FIFO.
  always_comb begin
    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;
    last_word_d = last_word_q;
    overflow_d  = overflow_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    tx_tvalid   = 1'b0;
    tx_tdata    = '0;
    case (state_q)
      SYNC: begin
        tx_tvalid = active_q;
        tx_tdata  = active_q ? DRM_SYNC_WORD : '0;
        if (tx_tvalid && drm_to_uip.tready) begin
          if (sync_cnt_q == CNT_W'(SYNC_BEATS - 1)) state_d = RUN;
          else                                      sync_cnt_d = sync_cnt_q + 1'b1;
        end
      end
      RUN: begin
        tx_tvalid = ~fifo_empty;
        tx_tdata  = fifo_empty ? '0 : {{(32-BUS_W){1'b0}}, fifo_head};
        fifo_pop  = ~fifo_empty & drm_to_uip.tready;
        if (bus_word != last_word_q) begin
          last_word_d = bus_word;
          if (fifo_full && !fifo_pop) overflow_d = 1'b1;
          else                        fifo_push  = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  assign drm_to_uip.tvalid = tx_tvalid;
  assign drm_to_uip.tdata  = tx_tdata;
  assign uip_to_drm.tready = active_q;

  // RX decode: any accepted beat raises link_up; sync beats leave the response untouched.
  always_ff @(posedge drm_aclk) begin
    if (drm_arst) begin
      resp_q    <= '0;
      link_up_q <= 1'b0;
    end else if (uip_to_drm.tvalid && active_q) begin
      link_up_q <= 1'b1;
      if (uip_to_drm.tdata != DRM_SYNC_WORD) resp_q <= uip_to_drm.tdata[3:0];
    end
  end

  assign drm_bus_master_i_ack  = resp_q[BIT_ACK];
  assign drm_bus_master_i_intr = resp_q[BIT_INTR];
  assign drm_bus_master_i_sta  = resp_q[BIT_STA];
  assign drm_bus_master_i_dat  = resp_q[BIT_RDAT];
  assign link_up               = link_up_q;
  assign tx_overflow           = overflow_q;

endmodule

// File: tb/tb_drm_ctrl_axis_bridge.sv
// tb/tb_drm_ctrl_axis_bridge.sv - directed self-checking bench for drm_ctrl_axis_bridge
module tb_drm_ctrl_axis_bridge;

  logic       clk = 1'b0;
  logic       arst;
  logic       cs, cyc, we, dat;
  logic [1:0] adr;
  logic       ack, intr, sta, rdat;
  logic       link_up, tx_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] beats[$];
  logic [31:0] exp_words[$];

  drm_ctrl_axis_bridge_if tx_if ();
  drm_ctrl_axis_bridge_if rx_if ();

  drm_ctrl_axis_bridge #(.FIFO_DEPTH(4), .SYNC_BEATS(16)) dut (
    .drm_aclk              (clk),
    .drm_arst              (arst),
    .drm_bus_master_o_cs   (cs),
    .drm_bus_master_o_cyc  (cyc),
    .drm_bus_master_o_we   (we),
    .drm_bus_master_o_dat  (dat),
    .drm_bus_master_o_adr  (adr),
    .drm_bus_master_i_ack  (ack),
    .drm_bus_master_i_intr (intr),
    .drm_bus_master_i_sta  (sta),
    .drm_bus_master_i_dat  (rdat),
    .drm_to_uip            (tx_if),
    .uip_to_drm            (rx_if),
    .link_up               (link_up),
    .tx_overflow           (tx_overflow)
  );

  always #5 clk = ~clk;

  // Record accepted TX beats midway through the cycle, when inputs and outputs are settled.
  always @(negedge clk) begin
    if (!arst && tx_if.tvalid && tx_if.tready) beats.push_back(tx_if.tdata);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic [5:0] w);
    cs  = w[5];
    cyc = w[4];
    adr = w[3:2];
    we  = w[1];
    dat = w[0];
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_count"}, beats.size(), exp_words.size());
    for (int i = 0; i < beats.size() && i < exp_words.size(); i++)
      chk($sformatf("%s_%0d", tag, i), beats[i], exp_words[i]);
  endtask

  task automatic expect_sync_run(input string tag);
    exp_words.delete();
    for (int i = 0; i < 16; i++) exp_words.push_back(32'hFFFF_FFFF);
    check_beats(tag);
  endtask

  initial begin
    arst         = 1'b1;
    tx_if.tready = 1'b0;
    rx_if.tvalid = 1'b0;
    rx_if.tdata  = '0;
    set_bus(6'h00);
    repeat (3) tick();

    // Reset state
    chk("rst_tvalid", tx_if.tvalid, 0);
    chk("rst_tdata", tx_if.tdata, 0);
    chk("rst_rx_tready", rx_if.tready, 0);
    chk("rst_resp", {ack, intr, sta, rdat}, 0);
    chk("rst_link_up", link_up, 0);
    chk("rst_overflow", tx_overflow, 0);

    // Release with tready low: sync word must appear and be held.
    arst = 1'b0;
    tick();
    chk("sync_tvalid_rise", tx_if.tvalid, 1);
    chk("sync_tdata", tx_if.tdata, 32'hFFFF_FFFF);
    chk("rx_tready_up", rx_if.tready, 1);
    repeat (5) tick();
    chk("sync_hold_tvalid", tx_if.tvalid, 1);
    chk("sync_hold_tdata", tx_if.tdata, 32'hFFFF_FFFF);

    beats.delete();
    tx_if.tready = 1'b1;
    repeat (30) tick();
    expect_sync_run("sync1");
    chk("idle_tvalid", tx_if.tvalid, 0);

    // First bus change: word 0x39 one cycle later, then nothing while static.
    beats.delete();
    set_bus(6'h39);
    tick();
    chk("chg_tvalid", tx_if.tvalid, 1);
    chk("chg_tdata", tx_if.tdata, 32'h39);
    repeat (10) tick();
    exp_words = '{32'h39};
    check_beats("chg");

    // Fill FIFO, then push and pop in the same cycle: nothing dropped.
    tx_if.tready = 1'b0;
    set_bus(6'h01); tick();
    set_bus(6'h02); tick();
    set_bus(6'h04); tick();
    set_bus(6'h08); tick();
    chk("full_head", tx_if.tdata, 32'h01);
    beats.delete();
    tx_if.tready = 1'b1;
    set_bus(6'h10);
    tick();
    repeat (10) tick();
    exp_words = '{32'h01, 32'h02, 32'h04, 32'h08, 32'h10};
    check_beats("fullpop");
    chk("fullpop_no_ovf", tx_overflow, 0);

    // Five changes into a stalled depth-4 FIFO: fifth dropped, overflow set.
    tx_if.tready = 1'b0;
    set_bus(6'h11); tick();
    set_bus(6'h12); tick();
    set_bus(6'h14); tick();
    set_bus(6'h18); tick();
    set_bus(6'h30); tick();
    chk("ovf_flag", tx_overflow, 1);
    chk("ovf_head", tx_if.tdata, 32'h11);
    beats.delete();
    tx_if.tready = 1'b1;
    repeat (10) tick();
    exp_words = '{32'h11, 32'h12, 32'h14, 32'h18};
    check_beats("ovf");
    chk("ovf_sticky", tx_overflow, 1);

    // RX decode
    chk("link_pre", link_up, 0);
    rx_if.tvalid = 1'b1;
    rx_if.tdata  = 32'h0000_000A;
    tick();
    chk("rx_a_resp", {ack, intr, sta, rdat}, 4'b1010);
    chk("rx_a_link", link_up, 1);
    rx_if.tdata = 32'hFFFF_FFFF;
    tick();
    chk("rx_sync_hold", {ack, intr, sta, rdat}, 4'b1010);
    rx_if.tdata = 32'hABCD_EF05;
    tick();
    chk("rx_hi_ignored", {ack, intr, sta, rdat}, 4'b0101);
    rx_if.tvalid = 1'b0;
    rx_if.tdata  = 32'h0000_000F;
    tick();
    chk("rx_idle_hold", {ack, intr, sta, rdat}, 4'b0101);

    // Mid-RUN reset with three buffered words.
    tx_if.tready = 1'b0;
    set_bus(6'h21); tick();
    set_bus(6'h22); tick();
    set_bus(6'h24); tick();
    chk("pre_rst_head", tx_if.tdata, 32'h21);
    arst = 1'b1;
    set_bus(6'h00);
    tick();
    chk("mrst_tvalid", tx_if.tvalid, 0);
    chk("mrst_tdata", tx_if.tdata, 0);
    chk("mrst_rx_tready", rx_if.tready, 0);
    chk("mrst_resp", {ack, intr, sta, rdat}, 0);
    chk("mrst_link", link_up, 0);
    chk("mrst_ovf", tx_overflow, 0);
    arst = 1'b0;
    beats.delete();
    tx_if.tready = 1'b1;
    repeat (30) tick();
    expect_sync_run("sync2");
    chk("post_rst_idle", tx_if.tvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
